sad_sequencer: RTL and testbench
================================

# sad_sequencer

Sequences the 8-lane absolute-difference array across one 8x8 block for every fractional candidate position in the FME stage. It requests rows from the pixel buffer, accumulates the eight per-lane differences into a per-candidate SAD, and tracks the minimum. It reports the winning candidate index and its SAD to the motion-vector refinement logic.

## Interface
- DATAWIDTH, 8, width of each pixel and each absolute-difference lane
- NUM_CAND, 9, candidate positions per block (indices 0..NUM_CAND-1)
- ROWS, 8, rows per block
- SADWIDTH, 14, SAD accumulator/output width (8*ROWS*(2^DATAWIDTH-1) must fit)
- IDXW, 4, candidate index width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a block evaluation; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE exits
- row_req  out  1  row request to pixel buffer
- row_cand  out  IDXW  candidate index of requested row
- row_idx  out  3  row number of requested row
- row_ack  in  1  buffer accepts request; transfer when row_req && row_ack
- ad_valid  in  1  absolute-difference array outputs valid for the accepted row
- ad_in  in  8*DATAWIDTH  packed lanes out_0 (LSBs) .. out_7 (MSBs) of the AD array
- done  out  1  one-cycle pulse: results valid
- best_idx  out  IDXW  index of minimum-SAD candidate, held until next start
- best_sad  out  SADWIDTH  minimum SAD, held until next start

## Operation
- States: IDLE, REQ, WAIT, CMP, DONE.
- IDLE: on start=1 -> REQ; cand=0, row=0, acc=0, running min=all ones, running idx=0.
- REQ: row_req=1, row_cand=cand, row_idx=row. On row_ack -> WAIT. Without ack, stay; request fields stable.
- WAIT: row_req=0. On ad_valid: acc <= acc + sum of 8 lanes (unsigned, zero-extended to SADWIDTH); if row==ROWS-1 -> CMP, else row++ -> REQ. ad_valid outside WAIT ignored.
- CMP (1 cycle): if acc < running min (strict), min<=acc, idx<=cand; ties keep lower index. If cand==NUM_CAND-1 -> DONE; else cand++, row=0, acc=0 -> REQ.
- DONE (1 cycle): best_idx/best_sad <= running idx/min, done=1 -> IDLE.
- start outside IDLE ignored; start in DONE's cycle also ignored.
- row_cand/row_idx are 0 whenever row_req=0.
- Arithmetic: no overflow possible at defaults (max 64*255=16320 < 2^14); no saturation logic.

## Timing
- Reset values: busy=0, row_req=0, row_cand=0, row_idx=0, done=0, best_idx=0, best_sad=0; state IDLE.
- rst mid-operation: next cycle in IDLE with all outputs at reset values; partial results discarded; best_* cleared.
- start accepted at edge k: busy=1 and row_req=1 from cycle k+1.
- Minimum per row: 2 cycles (ack in REQ's first cycle, ad_valid in WAIT's first cycle). Minimum per candidate: 2*ROWS+1 = 17.
- Minimum start-to-done: 1 + NUM_CAND*17 = 154 cycles at defaults; done and best_* update in same cycle; busy drops the cycle after done.
- ack stalls and ad_valid gaps add cycles 1:1; no timeout.

## Test plan
- All ad_in lanes 0, immediate ack/valid -> done 154 cycles after start, best_idx=0, best_sad=0.
- Candidate c rows give lane value (9-c) -> per-candidate SAD 64*(9-c); best_idx=8, best_sad=64.
- All lanes 255 every row -> best_sad=16320, best_idx=0 (ties keep lowest index).
- row_ack delayed 3 cycles per request, ad_valid delayed 2 -> row_cand/row_idx stable while waiting, results match zero-stall run, done at 1+9*(8*7+1)=514 cycles.
- start pulsed while busy, ad_valid pulsed in REQ -> both ignored; results unchanged.
- rst asserted in candidate 4 row 5 -> next cycle busy=0, best_sad=0; fresh start yields correct results.

Source files
------------

// File: rtl/sad_sequencer.sv
// Sequences the 8-lane AD array over an 8x8 block for each fractional
// candidate, accumulates per-candidate SAD and reports the minimum.
module sad_sequencer #(
   parameter int DATAWIDTH = 8,
   parameter int NUM_CAND  = 9,
   parameter int ROWS      = 8,
   parameter int SADWIDTH  = 14,
   parameter int IDXW      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   row_req,
   output logic [IDXW-1:0]        row_cand,
   output logic [2:0]             row_idx,
   input  logic                   row_ack,
   input  logic                   ad_valid,
   input  logic [8*DATAWIDTH-1:0] ad_in,
   output logic                   done,
   output logic [IDXW-1:0]        best_idx,
   output logic [SADWIDTH-1:0]    best_sad
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CMP,
      S_DONE
   } state_e;

   localparam logic [2:0]      LAST_ROW  = 3'(ROWS - 1);
   localparam logic [IDXW-1:0] LAST_CAND = IDXW'(NUM_CAND - 1);

   state_e                state_q, state_d;
   logic [IDXW-1:0]       cand_q, cand_d;
   logic [2:0]            row_q, row_d;
   logic [SADWIDTH-1:0]   acc_q, acc_d;
   logic [SADWIDTH-1:0]   min_q, min_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [IDXW-1:0]       best_idx_q, best_idx_d;
   logic [SADWIDTH-1:0]   best_sad_q, best_sad_d;

   logic [SADWIDTH-1:0]   row_sum;
   logic                  better;
   logic [SADWIDTH-1:0]   win_sad;
   logic [IDXW-1:0]       win_idx;

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < 8; i++) begin
         row_sum = row_sum
                 + SADWIDTH'(ad_in[i*DATAWIDTH +: DATAWIDTH]);
      end
   end

   // Strict compare so equal SADs keep the earlier (lower) index.
   always_comb begin
      better  = (acc_q < min_q);
      win_sad = better ? acc_q  : min_q;
      win_idx = better ? cand_q : idx_q;
   end

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      row_d      = row_q;
      acc_d      = acc_q;
      min_d      = min_q;
      idx_d      = idx_q;
      best_idx_d = best_idx_q;
      best_sad_d = best_sad_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               cand_d  = '0;
               row_d   = '0;
               acc_d   = '0;
               min_d   = '1;
               idx_d   = '0;
            end
         end
         S_REQ: begin
            if (row_ack) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ad_valid) begin
               acc_d = acc_q + row_sum;
               if (row_q == LAST_ROW) begin
                  state_d = S_CMP;
               end else begin
                  row_d   = row_q + 3'd1;
                  state_d = S_REQ;
               end
            end
         end
         S_CMP: begin
            min_d = win_sad;
            idx_d = win_idx;
            if (cand_q == LAST_CAND) begin
               // Publish together with the final compare so done and
               // best_* become visible in the same cycle.
               best_sad_d = win_sad;
               best_idx_d = win_idx;
               state_d    = S_DONE;
            end else begin
               cand_d  = cand_q + IDXW'(1);
               row_d   = '0;
               acc_d   = '0;
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cand_q     <= '0;
         row_q      <= '0;
         acc_q      <= '0;
         min_q      <= '0;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_sad_q <= '0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         row_q      <= row_d;
         acc_q      <= acc_d;
         min_q      <= min_d;
         idx_q      <= idx_d;
         best_idx_q <= best_idx_d;
         best_sad_q <= best_sad_d;
      end
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      row_req  = (state_q == S_REQ);
      row_cand = row_req ? cand_q : '0;
      row_idx  = row_req ? row_q  : '0;
      done     = (state_q == S_DONE);
      best_idx = best_idx_q;
      best_sad = best_sad_q;
   end

endmodule

// File: tb/tb_sad_sequencer.sv
// Directed bench for sad_sequencer: drives the row buffer / AD array side
// cycle by cycle and scores results against a reference SAD model.
module tb_sad_sequencer;

   localparam int NC = 9;
   localparam int RW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        row_req;
   logic [3:0]  row_cand;
   logic [2:0]  row_idx;
   logic        row_ack;
   logic        ad_valid;
   logic [63:0] ad_in;
   logic        done;
   logic [3:0]  best_idx;
   logic [13:0] best_sad;

   sad_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .row_req  (row_req),
      .row_cand (row_cand),
      .row_idx  (row_idx),
      .row_ack  (row_ack),
      .ad_valid (ad_valid),
      .ad_in    (ad_in),
      .done     (done),
      .best_idx (best_idx),
      .best_sad (best_sad)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int sad;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lane(int m, int c, int r, int l);
      case (m)
         0:       return 0;
         1:       return 9 - c;
         2:       return 255;
         3:       return (c == 3 || c == 6) ? 1 : 5;
         default: return ((c * 5 + 3) % 9) * (l + 1) + r;
      endcase
   endfunction

   function automatic logic [63:0] row_bus(int m, int c, int r);
      logic [63:0] v;
      v = '0;
      for (int l = 0; l < 8; l++) begin
         v[l*8 +: 8] = 8'(lane(m, c, r, l));
      end
      return v;
   endfunction

   task automatic push_exp(int m);
      res_t e;
      int   s;
      e.idx = 0;
      e.sad = 1 << 30;
      for (int c = 0; c < NC; c++) begin
         s = 0;
         for (int r = 0; r < RW; r++)
            for (int l = 0; l < 8; l++)
               s += lane(m, c, r, l);
         if (s < e.sad) begin
            e.sad = s;
            e.idx = c;
         end
      end
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(int m, int ad, int vd, bit noise,
                      bit abort, int exp_cyc);
      res_t got;
      push_exp(m);
      cyc   = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      for (int c = 0; c < NC; c++) begin
         for (int r = 0; r < RW; r++) begin
            if (abort && c == 4 && r == 5) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
               sb.delete();
               chk("rst_busy", int'(busy), 0);
               chk("rst_req", int'(row_req), 0);
               chk("rst_done", int'(done), 0);
               chk("rst_best_sad", int'(best_sad), 0);
               chk("rst_best_idx", int'(best_idx), 0);
               return;
            end
            for (int i = 0; i < ad; i++) begin
               chk("stall_req", int'(row_req), 1);
               chk("stall_cand", int'(row_cand), c);
               chk("stall_row", int'(row_idx), r);
               if (noise) begin
                  ad_valid = 1'b1;
                  ad_in    = '1;
                  start    = 1'b1;
               end
               tick();
               ad_valid = 1'b0;
               start    = 1'b0;
            end
            chk("req", int'(row_req), 1);
            chk("req_cand", int'(row_cand), c);
            chk("req_row", int'(row_idx), r);
            row_ack = 1'b1;
            tick();
            row_ack = 1'b0;
            chk("wait_req", int'(row_req), 0);
            chk("wait_cand", int'(row_cand), 0);
            for (int i = 0; i < vd; i++) tick();
            ad_valid = 1'b1;
            ad_in    = row_bus(m, c, r);
            tick();
            ad_valid = 1'b0;
            ad_in    = '0;
         end
         chk("cmp_req", int'(row_req), 0);
         tick();
      end
      chk("done", int'(done), 1);
      chk("latency", cyc, exp_cyc);
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         got = sb.pop_front();
         chk("best_idx", int'(best_idx), got.idx);
         chk("best_sad", int'(best_sad), got.sad);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_pulse", int'(done), 0);
      chk("busy_drop", int'(busy), 0);
      chk("held_sad", int'(best_sad), got.sad);
      tick();
      chk("idle_start_ignored", int'(busy), 0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      row_ack  = 1'b0;
      ad_valid = 1'b0;
      ad_in    = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_req", int'(row_req), 0);
      chk("reset_cand", int'(row_cand), 0);
      chk("reset_row", int'(row_idx), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_best_idx", int'(best_idx), 0);
      chk("reset_best_sad", int'(best_sad), 0);

      run(0, 0, 0, 1'b0, 1'b0, 154);
      run(1, 0, 0, 1'b0, 1'b0, 154);
      run(2, 0, 0, 1'b0, 1'b0, 154);
      run(1, 3, 2, 1'b0, 1'b0, 514);
      run(1, 1, 0, 1'b1, 1'b0, 226);
      run(3, 0, 0, 1'b0, 1'b0, 154);
      run(4, 0, 1, 1'b0, 1'b0, 226);
      run(1, 0, 0, 1'b0, 1'b1, 0);
      run(4, 0, 0, 1'b0, 1'b0, 154);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
